// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 set-2 keyboard decoder.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } dec_state_t;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;
  localparam logic [7:0] PS2_BAT   = 8'hAA;
  localparam logic [7:0] PS2_ACK   = 8'hFA;

  // Bytes that follow E1 in the Pause make sequence.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  localparam logic [8:0] KEY_SPACE = 9'h029;
  localparam logic [8:0] KEY_RIGHT = 9'h174;
  localparam logic [8:0] KEY_LEFT  = 9'h16B;
  localparam logic [8:0] KEY_UP    = 9'h175;
  localparam logic [8:0] KEY_DOWN  = 9'h172;
  localparam logic [8:0] KEY_ESC   = 9'h076;
  localparam logic [8:0] KEY_ENTER = 9'h05A;
  localparam logic [8:0] KEY_R     = 9'h02D;

  // Keyboard status/response bytes that never denote a key.
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == PS2_BAT) || (b == PS2_ACK) || (b == 8'hFC) ||
           (b == 8'hEE) || (b == 8'h00) || (b == 8'hFF);
  endfunction

  function automatic logic key_match(input logic [8:0] entry,
                                     input logic [8:0] code,
                                     input logic       use_ext);
    return (entry[7:0] == code[7:0]) && (!use_ext || (entry[8] == code[8]));
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 line receiver: synchronise, deglitch clock, shift in 11-bit frames,
// check start/parity/stop and abort stalled frames.
module ps2_rx_frame #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       timeout
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    byte_q, byte_d;
  logic          valid_q, valid_d, err_q, err_d, to_q, to_d;
  logic          fall;

  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = filt_cnt_q;
    if (clk_s2_q == filt_q) begin
      filt_cnt_d = '0;
    end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
      filt_d     = clk_s2_q;
      filt_cnt_d = '0;
    end else begin
      filt_cnt_d = filt_cnt_q + 1'b1;
    end
    fall = filt_q & ~filt_d;
  end

  // shift_q fills LSB-first: [0]=start, [8:1]=data, [9]=parity.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    to_cnt_d  = to_cnt_q;
    byte_d    = byte_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    to_d      = 1'b0;
    if (fall) begin
      to_cnt_d = '0;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = '0;
        if (!shift_q[0] && dat_s2_q && (^shift_q[9:1])) begin
          valid_d = 1'b1;
          byte_d  = shift_q[8:1];
        end else begin
          err_d = 1'b1;
        end
      end else begin
        shift_d   = {dat_s2_q, shift_q[9:1]};
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        to_d      = 1'b1;
        bit_cnt_d = '0;
        to_cnt_d  = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      to_cnt_q   <= '0;
      byte_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      dat_s1_q   <= ps2_data;
      dat_s2_q   <= dat_s1_q;
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      to_cnt_q   <= to_cnt_d;
      byte_q     <= byte_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      to_q       <= to_d;
    end
  end

  assign rx_byte    = byte_q;
  assign byte_valid = valid_q;
  assign frame_err  = err_q;
  assign timeout    = to_q;

endmodule

// File: rtl/ps2_key_matrix.sv
// Set-2 scan-code decoder with a configurable table of held keys and
// one-cycle press/release pulses.
module ps2_key_matrix
  import ps2_pkg::*;
#(
  parameter int                      NUM_KEYS       = 8,
  parameter logic [NUM_KEYS*9-1:0]   KEY_CODES      = {KEY_R, KEY_ENTER, KEY_ESC, KEY_DOWN,
                                                       KEY_UP, KEY_LEFT, KEY_RIGHT, KEY_SPACE},
  parameter bit                      MATCH_EXT      = 1'b1,
  parameter int                      FILTER_LEN     = 8,
  parameter int                      TIMEOUT_CYCLES = 200000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  input  logic                clear_all,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                code_valid,
  output logic [8:0]          last_code,
  output logic                last_break,
  output logic [7:0]          err_count
);

  logic [7:0] rx_byte;
  logic       byte_valid, frame_err, timeout;

  ps2_rx_frame #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err),
    .timeout   (timeout)
  );

  dec_state_t          state_q, state_d;
  logic [2:0]          skip_q, skip_d;
  logic                res_valid, res_brk;
  logic [8:0]          res_code;
  logic [NUM_KEYS-1:0] held_q, held_d, press_q, release_q;
  logic                code_valid_q, last_break_q;
  logic [8:0]          last_code_q;
  logic [7:0]          err_q;

  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    res_valid = 1'b0;
    res_brk   = 1'b0;
    res_code  = '0;
    if (frame_err || timeout) begin
      state_d = ST_IDLE;
      skip_d  = '0;
    end else if (byte_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (rx_byte == PS2_EXT) begin
            state_d = ST_EXT;
          end else if (rx_byte == PS2_BRK) begin
            state_d = ST_BRK;
          end else if (rx_byte == PS2_PAUSE) begin
            state_d = ST_SKIP;
            skip_d  = PAUSE_SKIP;
          end else if (!is_ignored(rx_byte)) begin
            res_valid = 1'b1;
            res_code  = {1'b0, rx_byte};
          end
        end
        ST_EXT: begin
          if (rx_byte == PS2_BRK) begin
            state_d = ST_EXT_BRK;
          end else if (rx_byte != PS2_EXT) begin
            res_valid = 1'b1;
            res_code  = {1'b1, rx_byte};
            state_d   = ST_IDLE;
          end
        end
        ST_BRK: begin
          res_valid = 1'b1;
          res_brk   = 1'b1;
          res_code  = {1'b0, rx_byte};
          state_d   = ST_IDLE;
        end
        ST_EXT_BRK: begin
          res_valid = 1'b1;
          res_brk   = 1'b1;
          res_code  = {1'b1, rx_byte};
          state_d   = ST_IDLE;
        end
        ST_SKIP: begin
          skip_d = skip_q - 1'b1;
          if (skip_q == 3'd1) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // clear_all overrides any resolution landing in the same cycle.
  always_comb begin
    held_d = held_q;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (res_valid && key_match(KEY_CODES[9*i +: 9], res_code, MATCH_EXT))
        held_d[i] = ~res_brk;
    end
    if (clear_all) held_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      skip_q       <= '0;
      held_q       <= '0;
      press_q      <= '0;
      release_q    <= '0;
      code_valid_q <= 1'b0;
      last_code_q  <= '0;
      last_break_q <= 1'b0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      skip_q       <= skip_d;
      held_q       <= held_d;
      press_q      <= held_d & ~held_q;
      release_q    <= held_q & ~held_d;
      code_valid_q <= res_valid;
      if (res_valid) begin
        last_code_q  <= res_code;
        last_break_q <= res_brk;
      end
      if ((frame_err || timeout) && (err_q != 8'hFF)) err_q <= err_q + 1'b1;
    end
  end

  assign key_held    = held_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign code_valid  = code_valid_q;
  assign last_code   = last_code_q;
  assign last_break  = last_break_q;
  assign err_count   = err_q;

endmodule
